// File: rtl/descriptor_scheduler.sv
// Round-robin scheduler that funnels NUM_CH descriptor sources into one
// descriptor_to_axis generator. It tags each descriptor with a channel ID and absorbs zero-length descriptors.
module descriptor_scheduler #(
    parameter int NUM_CH     = 4,
    parameter int ID_WIDTH   = 10,
    parameter int CH_ID_BASE = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable_i,
    input  logic [NUM_CH*48-1:0]     ch_desc_data_i,
    input  logic [NUM_CH-1:0]        ch_desc_valid_i,
    output logic [NUM_CH-1:0]        ch_desc_ready_o,
    output logic [48+ID_WIDTH-1:0]   out_descriptor_data_o,
    output logic                     out_descriptor_valid_o,
    input  logic                     out_descriptor_ready_i,
    output logic [15:0]              drop_count_o,
    output logic                     busy_o
);

    localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic {ST_EMPTY, ST_FULL} state_t;

    state_t                   state_q;
    logic [48+ID_WIDTH-1:0]   out_data_q;
    logic [PTR_W-1:0]         last_grant_q;
    logic [15:0]              drop_q;

    logic                     pop;
    logic                     slot_free;
    logic                     grant_vld;
    logic [PTR_W-1:0]         winner;
    logic                     found;
    logic [47:0]              win_desc;
    logic [ID_WIDTH-1:0]      win_id;
    logic [31:0]              id_sum;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign pop       = (state_q == ST_FULL) && out_descriptor_ready_i;
    assign slot_free = (state_q == ST_EMPTY) || pop;

    // Search starts just after the last winner so every source gets a turn.
    always_comb begin
        int idx;
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int k = 1; k <= NUM_CH; k++) begin
            idx = (int'(last_grant_q) + k) % NUM_CH;
            if (!found && ch_desc_valid_i[idx]) begin
                found  = 1'b1;
                winner = PTR_W'(idx);
            end
        end
    end

    assign grant_vld = enable_i && slot_free && found && !reset;
    assign win_desc  = ch_desc_data_i[48*winner +: 48];
    assign id_sum    = 32'(CH_ID_BASE) + 32'(winner);
    assign win_id    = id_sum[ID_WIDTH-1:0];

    always_comb begin
        ch_desc_ready_o = '0;
        if (grant_vld) ch_desc_ready_o[winner] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_EMPTY;
            out_data_q   <= '0;
            last_grant_q <= PTR_W'(NUM_CH - 1);
            drop_q       <= '0;
        end else if (grant_vld) begin
            last_grant_q <= winner;
            if (win_desc[15:0] != 16'd0) begin
                out_data_q <= {win_id, win_desc};
                state_q    <= ST_FULL;
            end else begin
                // Zero-length: the source handshake completes but nothing is forwarded.
                drop_q <= sat_inc(drop_q);
                if (pop) state_q <= ST_EMPTY;
            end
        end else if (pop) begin
            state_q <= ST_EMPTY;
        end
    end

    assign out_descriptor_valid_o = (state_q == ST_FULL);
    assign out_descriptor_data_o  = out_data_q;
    assign drop_count_o           = drop_q;
    assign busy_o                 = (state_q == ST_FULL) || (|ch_desc_valid_i);

endmodule

// File: doc/descriptor_scheduler.md
Name: descriptor_scheduler

Overview:
- Round-robin scheduler that shares one descriptor_to_axis generator between NUM_CH descriptor sources.
- Each source supplies {pause[31:0], length[15:0]}. The block tags the winner with its channel ID, registers it, and drives the generator's descriptor valid/ready port.
- Zero-length descriptors are absorbed and counted, never forwarded.

Parameters:
- NUM_CH, 4, number of requesting sources (2..16).
- ID_WIDTH, 10, channel field width; must match the generator.
- CH_ID_BASE, 0, channel ID of source 0. Source i is tagged CH_ID_BASE+i, truncated to ID_WIDTH.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- enable_i  in  1  global grant enable.
- ch_desc_data_i  in  NUM_CH*48  source i occupies bits [48*i +: 48] = {pause[31:0], length[15:0]}.
- ch_desc_valid_i  in  NUM_CH  per-source valid.
- ch_desc_ready_o  out  NUM_CH  per-source ready; at most one bit set.
- out_descriptor_data_o  out  48+ID_WIDTH  {channel, pause[31:0], length[15:0]} to the generator.
- out_descriptor_valid_o  out  1  output descriptor valid.
- out_descriptor_ready_i  in  1  generator ready.
- drop_count_o  out  16  count of zero-length descriptors absorbed; saturating.
- busy_o  out  1  high when the output register is full or any ch_desc_valid_i is set.

Behaviour:
- Reset values (reset high at a rising clk edge):
  - out_descriptor_valid_o=0, out_descriptor_data_o=0, drop_count_o=0.
  - Round-robin pointer last_grant=NUM_CH-1, so source 0 has first priority.
  - ch_desc_ready_o=0 combinationally while reset is high.
  - A pending output descriptor is discarded, not delivered.
- Output register FSM has two states:
  - EMPTY: out_descriptor_valid_o=0.
  - FULL: out_descriptor_valid_o=1, data held stable until out_descriptor_ready_i=1.
- slot_free = EMPTY, or (FULL and out_descriptor_ready_i).
- Arbitration (combinational, every cycle):
  - Runs only when enable_i=1, slot_free=1 and at least one ch_desc_valid_i bit is set.
  - Winner = first set valid bit searching last_grant+1, last_grant+2, ... modulo NUM_CH.
  - ch_desc_ready_o[winner]=1 in that cycle; all other bits 0.
  - At the clock edge last_grant <= winner.
- Load (winner length != 0):
  - Output register <= {CH_ID_BASE+winner, pause, length}; state = FULL next cycle.
  - Simultaneous pop of the old descriptor and load of the new one is allowed, giving one descriptor per cycle sustained throughput.
- Drop (winner length == 0):
  - Source handshake still completes and the pointer still advances.
  - Output register is not loaded; drop_count_o increments, saturating at 16'hFFFF.
  - If FULL and popped in the same cycle, the next state is EMPTY.
- No grant: if FULL and popped, next state is EMPTY; otherwise state is unchanged.
- Latency: source handshake at cycle N gives out_descriptor_valid_o=1 at cycle N+1. No combinational path from ch_desc_valid_i to out_descriptor_valid_o.
- enable_i=0: no new grants, ch_desc_ready_o=0. A descriptor already held FULL is still presented and can be accepted. Deasserting enable_i never drops a descriptor.
- A source that deasserts valid before being granted loses its turn without side effects. The pointer moves only on a completed grant.
- Single requester: granted every slot_free cycle regardless of pointer position.
- Pointer wraparound: after last_grant=NUM_CH-1, search starts at 0.
- AXI-style rules:
  - out_descriptor_data_o changes only while EMPTY or on a pop cycle.
  - out_descriptor_valid_o never falls without a handshake, except on reset.

Test Plan:
1. Reset, then sources 0..3 all valid continuously, out_descriptor_ready_i=1 → grants in order 0,1,2,3,0,...; one output per cycle; channel field 0,1,2,3; first out_descriptor_valid_o one cycle after the first grant.
2. Only source 2 valid with length=16'd64, pause=32'd5; out_descriptor_ready_i held 0 for 4 cycles → output = {10'd2, 32'd5, 16'd64}, stable for all 4 cycles; ch_desc_ready_o=0 throughout; a single grant once ready rises.
3. Source 1 presents length=0 three times, then length=8 → drop_count_o=3; only {1, pause, 8} is emitted; pointer advanced on every drop.
4. Output FULL, enable_i dropped to 0 with sources valid → held descriptor still accepted; no ch_desc_ready_o bit set until enable_i=1.
5. Reset asserted while FULL with out_descriptor_ready_i=0 → next cycle valid=0 and drop_count_o=0; first post-reset grant goes to source 0.
6. Force drop_count_o to 16'hFFFF via 65535 zero-length descriptors (or a fast-path force), then send one more zero-length descriptor → count stays 16'hFFFF.
